// File: rtl/uibi_arbiter.sv
// uibi_arbiter: round-robin arbiter and slave decoder for the UIBI internal bus
module uibi_arbiter #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int N_MASTER    = 4,
  parameter int N_SLAVE     = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_MASTER*XLEN-1:0]           m_dat_i,
  input  logic [N_MASTER*(XLEN-SLAVE_WIDTH)-1:0] m_addr,
  input  logic [N_MASTER*SLAVE_WIDTH-1:0]    m_num,
  input  logic [N_MASTER-1:0]                m_req,
  input  logic [N_MASTER-1:0]                m_wen,
  input  logic [N_MASTER*3-1:0]              m_mode,
  output logic [XLEN-1:0]                    m_dat_o,
  output logic [N_MASTER-1:0]                m_ready,
  output logic [XLEN-1:0]                    s_dat_o,
  output logic [XLEN-SLAVE_WIDTH-1:0]        s_addr,
  output logic                               s_wen,
  output logic [2:0]                         s_mode,
  output logic [N_SLAVE-1:0]                 s_req,
  input  logic [N_SLAVE*XLEN-1:0]            s_dat_i,
  input  logic [N_SLAVE-1:0]                 s_ready,
  output logic                               err_nodev,
  output logic                               err_timeout
);
  localparam int AW = XLEN - SLAVE_WIDTH;
  localparam int GW = $clog2(N_MASTER);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d, last_q, last_d;
  logic [SLAVE_WIDTH-1:0] tgt_q, tgt_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [GW-1:0]          hi, lo, pick;
  logic                   hi_v;
  logic [SLAVE_WIDTH-1:0] num_pick;
  logic [XLEN-1:0]        g_dat, sel_dat;
  logic [AW-1:0]          g_addr;
  logic                   g_wen;
  logic [2:0]             g_mode;
  logic                   tgt_ok, sel_rdy;
  logic                   busy, hit, tmo, nodev, done;
  always_comb begin
    hi_v = 1'b0;
    hi   = '0;
    lo   = '0;
    for (int j = N_MASTER - 1; j >= 0; j--) begin
      if (m_req[j] && GW'(j) > last_q) begin
        hi_v = 1'b1;
        hi   = GW'(j);
      end
      if (m_req[j] && GW'(j) <= last_q) lo = GW'(j);
    end
    pick = hi_v ? hi : lo;
  end
  always_comb begin
    num_pick = '0;
    g_dat    = '0;
    g_addr   = '0;
    g_wen    = 1'b0;
    g_mode   = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (pick == GW'(k)) num_pick = m_num[k*SLAVE_WIDTH +: SLAVE_WIDTH];
      if (grant_q == GW'(k)) begin
        g_dat  = m_dat_i[k*XLEN +: XLEN];
        g_addr = m_addr[k*AW +: AW];
        g_wen  = m_wen[k];
        g_mode = m_mode[k*3 +: 3];
      end
    end
  end
  always_comb begin
    tgt_ok  = 1'b0;
    sel_rdy = 1'b0;
    sel_dat = '0;
    for (int s = 0; s < N_SLAVE; s++) begin
      if (tgt_q == SLAVE_WIDTH'(s)) begin
        tgt_ok  = 1'b1;
        sel_rdy = s_ready[s];
        sel_dat = s_dat_i[s*XLEN +: XLEN];
      end
    end
  end
  always_comb begin
    busy  = state_q == BUSY;
    hit   = busy && tgt_ok && sel_rdy;
    tmo   = busy && tgt_ok && !sel_rdy && cnt_q == 16'(TIMEOUT);
    nodev = busy && !tgt_ok;
    done  = hit || tmo || nodev;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_MASTER - 1);
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (!busy && |m_req) begin
      state_d = BUSY;
      grant_d = pick;
      tgt_d   = num_pick;
      cnt_d   = '0;
    end else if (done) begin
      state_d = IDLE;
      last_d  = grant_q;
    end else if (busy) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 16'd1;
    end
  end
  always_comb begin
    s_dat_o     = busy ? g_dat : '0;
    s_addr      = busy ? g_addr : '0;
    s_wen       = busy && g_wen;
    s_mode      = busy ? g_mode : '0;
    m_dat_o     = hit ? sel_dat : '0;
    err_nodev   = nodev;
    err_timeout = tmo;
    for (int s = 0; s < N_SLAVE; s++) s_req[s] = busy && !tmo && tgt_q == SLAVE_WIDTH'(s);
    for (int k = 0; k < N_MASTER; k++) m_ready[k] = done && grant_q == GW'(k);
  end
endmodule

// File: tb/tb_uibi_arbiter.sv
// tb_uibi_arbiter: directed checks of arbitration, decoding, errors and reset
module tb_uibi_arbiter;
  localparam int XLEN = 32, SW = 4, NM = 4, NS = 8, AW = XLEN - SW;
  logic                 clk, rst;
  logic [NM*XLEN-1:0]   m_dat_i;
  logic [NM*AW-1:0]     m_addr;
  logic [NM*SW-1:0]     m_num;
  logic [NM-1:0]        m_req, m_wen, m_ready;
  logic [NM*3-1:0]      m_mode;
  logic [XLEN-1:0]      m_dat_o, s_dat_o;
  logic [AW-1:0]        s_addr;
  logic                 s_wen, err_nodev, err_timeout;
  logic [2:0]           s_mode;
  logic [NS-1:0]        s_req, s_ready;
  logic [NS*XLEN-1:0]   s_dat_i;
  int checks = 0, failures = 0;

  uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .N_MASTER(NM), .N_SLAVE(NS), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .m_dat_i(m_dat_i), .m_addr(m_addr), .m_num(m_num), .m_req(m_req),
    .m_wen(m_wen), .m_mode(m_mode), .m_dat_o(m_dat_o), .m_ready(m_ready), .s_dat_o(s_dat_o),
    .s_addr(s_addr), .s_wen(s_wen), .s_mode(s_mode), .s_req(s_req), .s_dat_i(s_dat_i),
    .s_ready(s_ready), .err_nodev(err_nodev), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_dat_i = '0; m_addr = '0; m_num = '0; m_req = '0; m_wen = '0; m_mode = '0;
    s_dat_i = '0; s_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("reset_sreq", 64'(s_req), 0);
    chk("reset_mready", 64'(m_ready), 0);
    chk("reset_errs", 64'({err_nodev, err_timeout}), 0);
    // single read from slave 2, ready in its 3rd request cycle
    m_req = 4'b0001; m_num[0 +: SW] = 4'd2; m_addr[0 +: AW] = 28'h123; m_mode[0 +: 3] = 3'b111;
    s_dat_i[2*XLEN +: XLEN] = 32'hDEAD_BEEF;
    #1;
    chk("idle_sreq", 64'(s_req), 0);
    chk("idle_saddr", 64'(s_addr), 0);
    tick();
    chk("rd_sreq1", 64'(s_req), 64'h04);
    chk("rd_saddr", 64'(s_addr), 64'h123);
    chk("rd_smode", 64'(s_mode), 64'h7);
    chk("rd_mready1", 64'(m_ready), 0);
    tick();
    chk("rd_sreq2", 64'(s_req), 64'h04);
    tick();
    s_ready = 8'b0000_0100;
    #1;
    chk("rd_sreq3", 64'(s_req), 64'h04);
    chk("rd_mready3", 64'(m_ready), 64'h1);
    chk("rd_data", 64'(m_dat_o), 64'hDEAD_BEEF);
    tick();
    m_req = '0; s_ready = '0;
    #1;
    chk("rd_idle_sreq", 64'(s_req), 0);
    chk("rd_idle_mready", 64'(m_ready), 0);
    chk("rd_idle_data", 64'(m_dat_o), 0);
    // write passthrough from master 2 to slave 5
    m_req = 4'b0100; m_wen = 4'b0100; m_mode[2*3 +: 3] = 3'b011;
    m_dat_i[2*XLEN +: XLEN] = 32'hA5A5_0000; m_num[2*SW +: SW] = 4'd5; m_addr[2*AW +: AW] = 28'h0ABCDEF;
    tick();
    chk("wr_sreq", 64'(s_req), 64'h20);
    chk("wr_swen", 64'(s_wen), 1);
    chk("wr_smode", 64'(s_mode), 64'h3);
    chk("wr_sdat", 64'(s_dat_o), 64'hA5A5_0000);
    chk("wr_saddr", 64'(s_addr), 64'h0ABCDEF);
    chk("wr_wait", 64'(m_ready), 0);
    s_ready = 8'b0010_0000;
    #1;
    chk("wr_mready", 64'(m_ready), 64'h4);
    tick();
    m_req = '0; m_wen = '0; s_ready = '0;
    #1;
    chk("wr_idle_swen", 64'(s_wen), 0);
    // nonexistent slave 12 from master 1; all slaves ready with data to prove it is ignored
    for (int s = 0; s < NS; s++) s_dat_i[s*XLEN +: XLEN] = 32'h1000_0000 + 32'(s);
    s_ready = '1;
    m_req = 4'b0010; m_num[1*SW +: SW] = 4'd12;
    tick();
    chk("nd_sreq", 64'(s_req), 0);
    chk("nd_mready", 64'(m_ready), 64'h2);
    chk("nd_data", 64'(m_dat_o), 0);
    chk("nd_err", 64'(err_nodev), 1);
    chk("nd_tmo", 64'(err_timeout), 0);
    tick();
    m_num[1*SW +: SW] = 4'd1;
    #1;
    chk("nd_idle_err", 64'(err_nodev), 0);
    tick();
    chk("nd_next_sreq", 64'(s_req), 64'h02);
    chk("nd_next_mready", 64'(m_ready), 64'h2);
    chk("nd_next_data", 64'(m_dat_o), 64'h1000_0001);
    chk("nd_next_err", 64'(err_nodev), 0);
    tick();
    m_req = '0; s_ready = '0;
    // timeout: master 0 to slave 3, never ready, TIMEOUT=5
    m_req = 4'b0001; m_num[0 +: SW] = 4'd3;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("to_sreq%0d", c), 64'(s_req), 64'h08);
      chk($sformatf("to_wait%0d", c), 64'(m_ready), 0);
      chk($sformatf("to_err%0d", c), 64'(err_timeout), 0);
      tick();
    end
    chk("to_sreq6", 64'(s_req), 0);
    chk("to_mready6", 64'(m_ready), 64'h1);
    chk("to_data6", 64'(m_dat_o), 0);
    chk("to_err6", 64'(err_timeout), 1);
    tick();
    m_req = '0;
    #1;
    chk("to_idle_err", 64'(err_timeout), 0);
    // asynchronous reset while slave 2 is being requested
    m_req = 4'b0100; m_num[2*SW +: SW] = 4'd2;
    tick();
    chk("rs_sreq_before", 64'(s_req), 64'h04);
    #1 rst = 1'b1;
    #1;
    chk("rs_sreq_async", 64'(s_req), 0);
    chk("rs_mready_async", 64'(m_ready), 0);
    chk("rs_err_async", 64'({err_nodev, err_timeout}), 0);
    // fairness after reset: every master requests, every slave ready, master k -> slave k
    m_req = 4'b1111; s_ready = '1;
    for (int k = 0; k < NM; k++) m_num[k*SW +: SW] = SW'(k);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_mready%0d", i), 64'(m_ready), 64'(1 << (i % 4)));
      chk($sformatf("rr_sreq%0d", i), 64'(s_req), 64'(1 << (i % 4)));
      chk($sformatf("rr_data%0d", i), 64'(m_dat_o), 64'h1000_0000 + 64'(i % 4));
      tick();
      chk($sformatf("rr_idle%0d", i), 64'(m_ready), 0);
      tick();
    end
    m_req = '0; s_ready = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uibi_arbiter.md
Name: uibi_arbiter

Overview:
Round-robin arbiter and address decoder that shares the UIBI internal bus between N_MASTER masters and N_SLAVE slaves. It accepts one master transaction at a time and routes it to the slave selected by that master's bus_num field. It returns the slave's read data and ready strobe to the granted master. It also terminates transactions that address a nonexistent slave or that time out.

Parameters:
XLEN, 32, data width
SLAVE_WIDTH, 4, slave-number width; address width AW = XLEN-SLAVE_WIDTH
N_MASTER, 4, number of masters (2..16)
N_SLAVE, 8, number of implemented slaves (1..2^SLAVE_WIDTH)
TIMEOUT, 255, max BUSY cycles before forced termination (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
m_dat_i  in  N_MASTER*XLEN  master write data, master k at slice k
m_addr  in  N_MASTER*AW  master addresses
m_num  in  N_MASTER*SLAVE_WIDTH  master target slave numbers
m_req  in  N_MASTER  master requests
m_wen  in  N_MASTER  master write enables
m_mode  in  N_MASTER*3  master bus modes (111/011/001/000)
m_dat_o  out  XLEN  read data, common to all masters
m_ready  out  N_MASTER  per-master completion strobe
s_dat_o  out  XLEN  write data to slaves (broadcast)
s_addr  out  AW  address to slaves (broadcast)
s_wen  out  1  write enable (broadcast)
s_mode  out  3  bus mode (broadcast)
s_req  out  N_SLAVE  per-slave request, one-hot or zero
s_dat_i  in  N_SLAVE*XLEN  slave read data
s_ready  in  N_SLAVE  slave completion strobes
err_nodev  out  1  one-cycle pulse when a transaction addresses slave >= N_SLAVE
err_timeout  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset, state=IDLE, grant=0, last=N_MASTER-1, cnt=0, and every output is 0; s_req drops immediately, including mid-transaction.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any m_req bit is set, register grant as the first requester found scanning last+1, last+2, ... (mod N_MASTER). Also latch tgt = m_num[grant] and clear cnt. Go to BUSY.
  - All outputs are 0 while in IDLE.
- BUSY, common rules:
  - s_dat_o, s_addr, s_wen and s_mode are combinationally muxed from the granted master's slices.
  - Masters hold all signals stable until they see m_ready.
- BUSY, tgt < N_SLAVE:
  - s_req[tgt]=1.
  - When s_ready[tgt]=1 in the same cycle: m_ready[grant]=1 and m_dat_o=s_dat_i[tgt]; at the edge, last<=grant and go to IDLE.
  - Otherwise cnt increments.
  - If cnt==TIMEOUT and s_ready[tgt]=0: s_req=0, m_ready[grant]=1, m_dat_o=0, err_timeout=1 for that cycle; last<=grant; go to IDLE.
- BUSY, tgt >= N_SLAVE: no s_req is asserted. In the first BUSY cycle, m_ready[grant]=1, m_dat_o=0 and err_nodev=1; then go to IDLE.
- Latency:
  - Minimum completion is 2 cycles from m_req (grant cycle, then first BUSY cycle) when the slave is ready combinationally.
  - Back-to-back transactions have one IDLE cycle between them.
- m_dat_o is 0 whenever no m_ready bit is set. At most one m_ready bit is set in any cycle.
- A master must deassert m_req the cycle after it sees m_ready unless it issues a new transaction. A held m_req re-arbitrates fairly: the same master loses priority to other requesters.
- m_req of the granted master dropping in BUSY is a protocol violation. The arbiter does not abort; the transaction finishes per the rules above.
- s_ready bits of non-targeted slaves are ignored.
- cnt is a 16-bit saturating counter compared with TIMEOUT.

Test Plan:
- Single read: m_req[0]=1, m_num=2, m_addr=0x123, m_mode=111; slave 2 asserts s_ready in its 3rd request cycle with data 0xDEADBEEF -> s_req=8'b0000_0100 for 3 cycles, s_addr=0x123, m_ready[0] pulses once with m_dat_o=0xDEADBEEF, then IDLE.
- Fairness: all 4 masters request continuously, each slave ready immediately -> grant order 0,1,2,3,0,1,... Each transaction takes 2 cycles, so the period is 8 cycles.
- Write passthrough: m_req[2]=1, m_wen=1, m_mode=011, m_dat_i[2]=0xA5A5_0000 -> s_wen=1, s_mode=011, s_dat_o=0xA5A50000 while s_req is set.
- Nonexistent slave: N_SLAVE=8, master 1 with m_num=12 -> no s_req bit asserted; m_ready[1]=1, m_dat_o=0, err_nodev=1 in the same cycle; next transaction proceeds normally.
- Timeout: TIMEOUT=5, slave 3 never ready -> s_req[3] high for 5 cycles. In the 6th BUSY cycle s_req=0, m_ready pulses, m_dat_o=0 and err_timeout=1.
- Reset mid-transaction: assert rst asynchronously while s_req[2]=1 -> s_req, m_ready and err outputs drop without waiting for clk. After release, the first grant goes to master 0 when all masters request.
